// File: rtl/fpu_mult_pkg.sv
// Shared constants and types for the sequential FPU multiply responder.
package fpu_mult_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [30:0] MAX_FIN = 31'h7F7FFFFF;

  localparam logic [1:0] RM_NEAR = 2'b00;
  localparam logic [1:0] RM_ZERO = 2'b01;
  localparam logic [1:0] RM_PINF = 2'b10;
  localparam logic [1:0] RM_NINF = 2'b11;

  typedef struct packed {
    logic [31:0] word;
    logic        ovf;
    logic        unf;
  } round_res_t;
endpackage

// File: rtl/fpu_round_unit.sv
// Combinational rounding, overflow saturation and flush-to-zero for a normalised product.
module fpu_round_unit
  import fpu_mult_pkg::*;
(
  input  logic              sign,
  input  logic [22:0]       frac,
  input  logic              guard,
  input  logic              sticky,
  input  logic signed [9:0] exp,
  input  logic [1:0]        mode,
  output round_res_t        res
);
  localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

  logic              inc, carry;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;

  always_comb begin
    inc = 1'b0;
    case (mode)
      RM_NEAR: inc = guard & (frac[0] | sticky);
      RM_ZERO: inc = 1'b0;
      RM_PINF: inc = ~sign & (guard | sticky);
      RM_NINF: inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
    // hidden bit is always 1 here, so a wrap of the fraction is exactly 1.0 with exp+1
    carry  = inc & (&frac);
    frac_r = frac + {22'b0, inc};
    exp_r  = exp + {9'b0, carry};

    res.ovf  = (exp_r >= EMAX);
    res.unf  = (exp_r <= 10'sd0);
    res.word = {sign, exp_r[7:0], frac_r};
    if (res.ovf) begin
      case (mode)
        RM_NEAR: res.word = {sign, POS_INF[30:0]};
        RM_ZERO: res.word = {sign, MAX_FIN};
        RM_PINF: res.word = sign ? {sign, MAX_FIN} : {sign, POS_INF[30:0]};
        default: res.word = sign ? {sign, POS_INF[30:0]} : {sign, MAX_FIN};
      endcase
    end else if (res.unf) begin
      res.word = {sign, 31'b0};
    end
  end
endmodule

// File: rtl/fpu_mult_seq_responder.sv
// Handshaked single-precision multiplier: radix-2 shift-add, one multiplier bit per clock.
module fpu_mult_seq_responder
  import fpu_mult_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beg_FSM,
  input  logic         rst_FSM,
  input  logic [W-1:0] Data_MX,
  input  logic [W-1:0] Data_MY,
  input  logic [1:0]   round_mode,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         ready_flag,
  output logic [W-1:0] F_ieee_result
);
  logic [2:0]        state;
  logic [31:0]       x, y;
  logic [1:0]        rm;
  logic              sign;
  logic signed [9:0] exp;
  logic [47:0]       mcd, prod;
  logic [23:0]       mlt;
  logic [4:0]        cnt;
  logic [22:0]       frac;
  logic              grd, stk;
  logic [31:0]       result;
  logic              ovf, unf, ready;

  logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, special;
  logic [31:0] spc_word;
  round_res_t  rnd;

  always_comb begin
    x_nan   = (&x[30:23]) & (|x[22:0]);
    y_nan   = (&y[30:23]) & (|y[22:0]);
    x_inf   = (&x[30:23]) & ~(|x[22:0]);
    y_inf   = (&y[30:23]) & ~(|y[22:0]);
    x_zero  = ~(|x[30:23]);
    y_zero  = ~(|y[30:23]);
    special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
    if (x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero))
      spc_word = QNAN;
    else if (x_inf | y_inf)
      spc_word = {x[31] ^ y[31], POS_INF[30:0]};
    else
      spc_word = {x[31] ^ y[31], 31'b0};
  end

  fpu_round_unit u_round (
    .sign   (sign),
    .frac   (frac),
    .guard  (grd),
    .sticky (stk),
    .exp    (exp),
    .mode   (rm),
    .res    (rnd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      x      <= '0;
      y      <= '0;
      rm     <= '0;
      sign   <= 1'b0;
      exp    <= '0;
      mcd    <= '0;
      prod   <= '0;
      mlt    <= '0;
      cnt    <= '0;
      frac   <= '0;
      grd    <= 1'b0;
      stk    <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      ready  <= 1'b0;
    end else if (rst_FSM) begin
      state <= S_IDLE;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (beg_FSM) begin
          x     <= Data_MX;
          y     <= Data_MY;
          rm    <= round_mode;
          state <= S_LOAD;
        end
        S_LOAD: begin
          sign <= x[31] ^ y[31];
          exp  <= 10'($signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - BIAS);
          mcd  <= {24'b0, 1'b1, x[22:0]};
          mlt  <= {1'b1, y[22:0]};
          prod <= '0;
          cnt  <= '0;
          if (special) begin
            result <= spc_word;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            ready  <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_MULT;
          end
        end
        S_MULT: begin
          if (mlt[0]) prod <= prod + mcd;
          mcd <= mcd << 1;
          mlt <= mlt >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23) state <= S_NORM;
        end
        S_NORM: begin
          if (prod[47]) begin
            exp  <= exp + 10'sd1;
            frac <= prod[46:24];
            grd  <= prod[23];
            stk  <= |prod[22:0];
          end else begin
            frac <= prod[45:23];
            grd  <= prod[22];
            stk  <= |prod[21:0];
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          result <= rnd.word;
          ovf    <= rnd.ovf;
          unf    <= rnd.unf;
          ready  <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign F_ieee_result  = result;
  assign overflow_flag  = ovf;
  assign underflow_flag = unf;
  assign ready_flag     = ready;
endmodule
